// File: rtl/vga_scan_driver.sv
// VGA raster timing: scan counters, active-low syncs, blanking-forced colour, frame/refresh ticks.
// Optional macro SYNC_DELAY_EN adds a second sync/display stage and registers rgb.
module vga_scan_driver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FRAME_DIV = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_bw,
    input  logic [5:0] fg_color,
    input  logic [5:0] bg_color,
    output logic [9:0] horiz_counter,
    output logic [9:0] vert_counter,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [5:0] rgb,
    output logic       frame_tick,
    output logic       refresh_tick
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam int         FW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0] FD_LAST = FW'(FRAME_DIV - 1);

    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          ftick_q, ftick_d;
    logic          rtick_q, rtick_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          h_wrap;

    // Sync/display terms are decoded from the current count and registered,
    // so they appear one clock after the count that produced them.
    always_comb begin
        h_wrap  = (h_q == H_LAST);
        h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d     = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        de_d    = (h_q < H_VIS) && (v_q < V_VIS);
        ftick_d = (h_q == 10'd0) && (v_q == V_VIS);
        fcnt_d  = fcnt_q;
        rtick_d = 1'b0;
        if (ftick_d) begin
            if (fcnt_q == FD_LAST) begin
                fcnt_d  = '0;
                rtick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            ftick_q <= 1'b0;
            rtick_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ftick_q <= ftick_d;
            rtick_q <= rtick_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign horiz_counter = h_q;
    assign vert_counter  = v_q;
    assign frame_tick    = ftick_q;
    assign refresh_tick  = rtick_q;

`ifdef SYNC_DELAY_EN
    // Second stage for renderers that deliver the pixel two clocks late.
    logic       hsync2_q, vsync2_q, de2_q;
    logic [5:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = 6'b0;
        if (de_q) begin
            rgb_d = pixel_bw ? fg_color : bg_color;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync2_q <= 1'b1;
            vsync2_q <= 1'b1;
            de2_q    <= 1'b0;
            rgb_q    <= 6'b0;
        end else begin
            hsync2_q <= hsync_q;
            vsync2_q <= vsync_q;
            de2_q    <= de_q;
            rgb_q    <= rgb_d;
        end
    end

    assign hsync      = hsync2_q;
    assign vsync      = vsync2_q;
    assign display_on = de2_q;
    assign rgb        = rgb_q;
`else
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = de_q;

    always_comb begin
        rgb = 6'b0;
        if (de_q) begin
            rgb = pixel_bw ? fg_color : bg_color;
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver on a shrunken raster so several frames fit in a short run.
module tb_vga_scan_driver;

    localparam int HV = 40, HF = 4, HS = 8, HB = 6;
    localparam int VV = 20, VF = 3, VS = 2, VB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FD = 3;
`ifdef SYNC_DELAY_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif

    logic       clk, reset, pixel_bw;
    logic [5:0] fg_color, bg_color;
    logic [9:0] horiz_counter, vert_counter;
    logic       hsync, vsync, display_on, frame_tick, refresh_tick;
    logic [5:0] rgb;
    logic [9:0] h1, v1;
    logic       hs1, vs1, de1, ft1, rt1;
    logic [5:0] rgb1;

    vga_scan_driver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FRAME_DIV(FD)
    ) dut (
        .clk(clk), .reset(reset), .pixel_bw(pixel_bw), .fg_color(fg_color), .bg_color(bg_color),
        .horiz_counter(horiz_counter), .vert_counter(vert_counter), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .rgb(rgb), .frame_tick(frame_tick), .refresh_tick(refresh_tick)
    );

    vga_scan_driver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FRAME_DIV(1)
    ) dut_div1 (
        .clk(clk), .reset(reset), .pixel_bw(pixel_bw), .fg_color(fg_color), .bg_color(bg_color),
        .horiz_counter(h1), .vert_counter(v1), .hsync(hs1), .vsync(vs1),
        .display_on(de1), .rgb(rgb1), .frame_tick(ft1), .refresh_tick(rt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         t;
        int         h, v;
        bit         hs, vs, de, ft, rt;
        logic [5:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   t_edges;
    int   phase = 0;
    bit   first_low_pending = 0;

    // Clock edges since the last reset release; the model works from this alone.
    always @(posedge clk or posedge reset) begin
        if (reset) t_edges <= 0;
        else       t_edges <= t_edges + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp_v);
        end
    endtask

    // Outputs after t edges reflect the raster position of edge t-LAG.
    function automatic exp_t model(input int t, input bit pix, input logic [5:0] fg, input logic [5:0] bg,
                                   input bit pixp, input logic [5:0] fgp, input logic [5:0] bgp);
        exp_t e;
        int p, ph, pv, q, tick_pos;
        e.t = t; e.h = t % HT; e.v = (t / HT) % VT;
        e.hs = 1; e.vs = 1; e.de = 0; e.ft = 0; e.rt = 0;
        if (t >= LAG) begin
            p  = t - LAG;
            ph = p % HT;
            pv = (p / HT) % VT;
            e.hs = !(ph >= HV + HF && ph < HV + HF + HS);
            e.vs = !(pv >= VV + VF && pv < VV + VF + VS);
            e.de = (ph < HV) && (pv < VV);
        end
        if (t >= 1) begin
            q = t - 1;
            tick_pos = VV * HT;
            if (q >= tick_pos && (q - tick_pos) % FT == 0) begin
                e.ft = 1;
                e.rt = (((q - tick_pos) / FT + 1) % FD) == 0;
            end
        end
`ifdef SYNC_DELAY_EN
        e.rgb = e.de ? (pixp ? fgp : bgp) : 6'h00;
`else
        e.rgb = e.de ? (pix ? fg : bg) : 6'h00;
`endif
        return e;
    endfunction

    bit         pix_p;
    logic [5:0] fg_p, bg_p;

    // mode 0: fixed 3F/03 with pixel toggling every clock; mode 1: random colours and pixels.
    task automatic run(input int n, input int mode);
        repeat (n) begin
            @(negedge clk);
            pix_p = pixel_bw; fg_p = fg_color; bg_p = bg_color;
            if (mode == 0) begin
                fg_color = 6'h3F; bg_color = 6'h03; pixel_bw = ~pixel_bw;
            end else begin
                fg_color = 6'($urandom); bg_color = 6'($urandom); pixel_bw = 1'($urandom);
            end
            sb.push_back(model(t_edges, pixel_bw, fg_color, bg_color, pix_p, fg_p, bg_p));
        end
    endtask

    // Monitor: pops the expectation for each sampled cycle and tracks pulse shapes.
    int de_cnt = 0, hs_low = 0, vs_low = 0, ft_cnt = 0, blank_bad = 0;
    int last_hs_fall = -1, last_vs_fall = -1, last_ft = -1;
    bit prev_hs = 1, prev_vs = 1, prev_ft = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("horiz_counter", int'(horiz_counter), e.h);
                chk("vert_counter", int'(vert_counter), e.v);
                chk("hsync", int'(hsync), int'(e.hs));
                chk("vsync", int'(vsync), int'(e.vs));
                chk("display_on", int'(display_on), int'(e.de));
                chk("rgb", int'(rgb), int'(e.rgb));
                chk("frame_tick", int'(frame_tick), int'(e.ft));
                chk("refresh_tick", int'(refresh_tick), int'(e.rt));
                chk("div1_frame_tick", int'(ft1), int'(e.ft));
                chk("div1_refresh_eq_frame", int'(rt1), int'(ft1));
                if (phase == 1 && e.t >= 1 && e.t <= 2 * FT) begin
                    de_cnt += int'(display_on);
                    hs_low += int'(!hsync);
                    vs_low += int'(!vsync);
                    ft_cnt += int'(frame_tick);
                    if (!display_on && rgb != 6'h00) blank_bad++;
                    if (e.t == 2 * FT) begin
                        chk("display_on_count_2frames", de_cnt, 2 * HV * VV);
                        chk("hsync_low_count_2frames", hs_low, 2 * VT * HS);
                        chk("vsync_low_count_2frames", vs_low, 2 * VS * HT);
                        chk("frame_tick_count_2frames", ft_cnt, 2);
                        chk("rgb_nonzero_in_blank", blank_bad, 0);
                    end
                end
                if (phase == 1 && e.t >= 2) begin
                    if (prev_hs && !hsync) begin
                        if (last_hs_fall >= 0) chk("hsync_period", e.t - last_hs_fall, HT);
                        last_hs_fall = e.t;
                    end
                    if (!prev_hs && hsync) chk("hsync_width", e.t - last_hs_fall, HS);
                    if (prev_vs && !vsync) begin
                        if (last_vs_fall >= 0) chk("vsync_period", e.t - last_vs_fall, FT);
                        last_vs_fall = e.t;
                    end
                    if (!prev_vs && vsync) chk("vsync_width", e.t - last_vs_fall, VS * HT);
                    if (frame_tick) begin
                        chk("frame_tick_width", int'(prev_ft), 0);
                        if (last_ft >= 0) chk("frame_tick_period", e.t - last_ft, FT);
                        last_ft = e.t;
                    end
                end
                if (phase == 2 && first_low_pending) begin
                    if (!hsync) begin
                        chk("first_hsync_low_after_reset", e.t, HV + HF + LAG);
                        first_low_pending = 0;
                    end else if (e.t > 2 * HT) begin
                        chk("first_hsync_low_timeout", e.t, HV + HF + LAG);
                        first_low_pending = 0;
                    end
                end
                prev_hs = hsync; prev_vs = vsync; prev_ft = frame_tick;
            end
        end
    end

    initial begin
        int target;
        reset = 1'b1; pixel_bw = 1'b0; fg_color = 6'h00; bg_color = 6'h00;
        pix_p = 1'b0; fg_p = 6'h00; bg_p = 6'h00;
        #1;
        chk("reset_hsync", int'(hsync), 1);
        chk("reset_display_on", int'(display_on), 0);
        run(3, 1);
        reset = 1'b0;
        phase = 1;
        run(FT, 0);
        // Stop inside both sync pulses of the fourth frame, then reset asynchronously.
        target = 3 * FT + (VV + VF) * HT + (HV + HF + 4);
        while (t_edges < target - 1) run(1, 1);
        @(posedge clk);
        #3;
        chk("pre_reset_hsync_low", int'(hsync), 0);
        chk("pre_reset_vsync_low", int'(vsync), 0);
        reset = 1'b1;
        #1;
        chk("async_reset_horiz", int'(horiz_counter), 0);
        chk("async_reset_vert", int'(vert_counter), 0);
        chk("async_reset_hsync", int'(hsync), 1);
        chk("async_reset_vsync", int'(vsync), 1);
        chk("async_reset_display_on", int'(display_on), 0);
        chk("async_reset_rgb", int'(rgb), 0);
        chk("async_reset_frame_tick", int'(frame_tick), 0);
        chk("async_reset_refresh_tick", int'(refresh_tick), 0);
        phase = 2;
        run(3, 1);
        reset = 1'b0;
        first_low_pending = 1;
        run(2 * FT + 100, 1);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, H_SYNC, default 96, and H_BACK, default 48, giving horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FRONT, default 10, V_SYNC, default 2, and V_BACK, default 33, giving vertical porch and sync widths in lines.
REQ-005 SHALL have parameter FRAME_DIV, default 60, the number of frames per refresh_tick.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port pixel_bw, input, 1 bit: registered pixel from the renderer, valid one clock after its counter value.
REQ-009 SHALL have ports fg_color and bg_color, input, 6 bits each, in {R1,R0,G1,G0,B1,B0} order.
REQ-010 SHALL have ports horiz_counter and vert_counter, output, 10 bits each: current scan position.
REQ-011 SHALL have ports hsync and vsync, output, 1 bit each: active-low sync.
REQ-012 SHALL have port display_on, output, 1 bit: visible-area flag, aligned with rgb.
REQ-013 SHALL have port rgb, output, 6 bits: colour to the pads.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-clock pulse per frame.
REQ-015 SHALL have port refresh_tick, output, 1 bit: one-clock pulse every FRAME_DIV frames, driving the renderer's slow_clk.

Function
REQ-016 The value H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800), and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-017 horiz_counter SHALL increment every clk and wrap from H_TOTAL-1 to 0.
REQ-018 vert_counter SHALL increment only on a horizontal wrap, and SHALL wrap from V_TOTAL-1 to 0 on the same edge that horiz_counter wraps.
REQ-019 hsync SHALL be registered, and SHALL be low for exactly H_SYNC clocks starting one clock after horiz_counter==H_VISIBLE+H_FRONT (656).
REQ-020 vsync SHALL be registered, and SHALL be low while vert_counter is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] ([490,491]), with the same one-clock lag.
REQ-021 display_on SHALL be registered, and SHALL be 1 one clock after (horiz_counter<H_VISIBLE && vert_counter<V_VISIBLE).
REQ-022 rgb SHALL equal fg_color when display_on && pixel_bw, bg_color when display_on && !pixel_bw, and 6'b0 otherwise (blanking forced).
REQ-023 frame_tick SHALL pulse for exactly one clock, on the clock after counters reach (0, V_VISIBLE), i.e. at the start of vblank.
REQ-024 A frame counter SHALL count frame_ticks 0..FRAME_DIV-1, and refresh_tick SHALL pulse on the same clock as the frame_tick that wraps it to 0.
REQ-025 With FRAME_DIV=1, refresh_tick SHALL equal frame_tick.
REQ-026 All counter compares SHALL be unsigned, 10 bits wide, and SHALL have no combinational path from pixel_bw to any output except rgb.

Reset
REQ-027 On reset assertion, the block SHALL immediately drive horiz_counter=0, vert_counter=0, hsync=1, vsync=1, display_on=0, rgb=0, frame_tick=0, refresh_tick=0, and frame counter=0.
REQ-028 On the first clk edge after reset deassertion, horiz_counter SHALL become 1, and display_on SHALL become 1.
REQ-029 Reset asserted mid-frame or mid-sync SHALL abort the frame, with no partial sync pulse completed after release.

Configuration
REQ-030 With macro SYNC_DELAY_EN defined, hsync, vsync and display_on SHALL gain one further register stage (2-clock lag), and rgb SHALL be registered, for 2-cycle-latency renderers.
REQ-031 Without SYNC_DELAY_EN, the lag SHALL be 1 clock and rgb SHALL be combinational per REQ-022.
REQ-032 Under SYNC_DELAY_EN, frame_tick and refresh_tick SHALL be unchanged.

Verification
REQ-033 The bench SHALL check: reset released, run 2 frames -> hsync low exactly 96 clocks per line, period 800; vsync low exactly 2 lines, period 525 lines (420000 clocks).
REQ-034 The bench SHALL check: count display_on over one frame -> exactly 307200 high clocks; rgb==0 on every display_on==0 clock.
REQ-035 The bench SHALL check: fg_color=6'h3F, bg_color=6'h03, pixel_bw toggled every clock -> rgb alternates 3F/03 in the visible area, 00 in blanking, with a 1-clock (or 2-clock under SYNC_DELAY_EN) alignment.
REQ-036 The bench SHALL check: FRAME_DIV=3 -> frame_tick every 420000 clocks, refresh_tick on every 3rd frame_tick only, each 1 clock wide.
REQ-037 The bench SHALL check: reset asserted at horiz_counter=700, vert_counter=490 (inside hsync and vsync) -> outputs are at reset values asynchronously, and after release the counters restart at 0 and the first hsync low occurs at clock 657.
REQ-038 The bench SHALL check: counters at (799, 524) -> the next edge gives (0, 0), and no frame_tick occurs.
